// File: rtl/rx_block_assembler.sv
// rtl/rx_block_assembler.sv - gathers UART bytes into BYTES-wide blocks behind a double-buffered output register
module rx_block_assembler #(
    parameter int BYTES     = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 d_in,
    input  logic                       rx_done,
    output logic [8*BYTES-1:0]         d_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(BYTES):0]     byte_count,
    output logic                       overflow,
    output logic                       timeout
);

    localparam int CW = $clog2(BYTES) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(BYTES);
    localparam logic [TW-1:0] IDLE_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t             state;
    logic [8*BYTES-1:0] asm_q;
    logic [8*BYTES-1:0] asm_wr;
    logic [TW-1:0]      idle_cnt;
    logic               out_free;
    int                 idx;
    int                 slot;

    assign out_free = !out_valid || out_ready;

    // Assembly register with the incoming byte merged in; a fresh block starts from all zeros.
    always_comb begin
        idx    = (byte_count < FULL_COUNT) ? int'(byte_count) : 0;
        slot   = MSB_FIRST ? (BYTES - 1 - idx) : idx;
        asm_wr = (state == S_IDLE) ? '0 : asm_q;
        asm_wr[8*slot +: 8] = d_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            asm_q      <= '0;
            idle_cnt   <= '0;
            d_out      <= '0;
            out_valid  <= 1'b0;
            byte_count <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
            // A pending load below overrides this clear on the same edge.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE, S_FILL: begin
                    if (rx_done) begin
                        asm_q    <= asm_wr;
                        idle_cnt <= '0;
                        if (byte_count == LAST_BYTE) begin
                            if (out_free) begin
                                d_out      <= asm_wr;
                                out_valid  <= 1'b1;
                                byte_count <= '0;
                                state      <= S_IDLE;
                            end else begin
                                byte_count <= FULL_COUNT;
                                state      <= S_FULL;
                            end
                        end else begin
                            byte_count <= byte_count + 1'b1;
                            state      <= S_FILL;
                        end
                    end else if (state == S_FILL && TIMEOUT > 0) begin
                        if (idle_cnt == IDLE_LAST) begin
                            timeout    <= 1'b1;
                            idle_cnt   <= '0;
                            byte_count <= '0;
                            state      <= S_IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (rx_done) begin
                        overflow <= 1'b1;
                    end
                    if (out_free) begin
                        d_out      <= asm_q;
                        out_valid  <= 1'b1;
                        byte_count <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    byte_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_block_assembler.sv
// tb/tb_rx_block_assembler.sv - directed self-checking bench for rx_block_assembler
module tb_rx_block_assembler;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   d_in;
    logic         rx_a, rx_b, rx_c;
    logic         ready_a, ready_b, ready_c;

    logic [127:0] d_out_a, d_out_c;
    logic [31:0]  d_out_b;
    logic         valid_a, valid_b, valid_c;
    logic [4:0]   cnt_a, cnt_c;
    logic [2:0]   cnt_b;
    logic         ovf_a, ovf_b, ovf_c;
    logic         to_a, to_b, to_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rx_block_assembler dut_a (
        .clk(clk), .reset(reset), .d_in(d_in), .rx_done(rx_a),
        .d_out(d_out_a), .out_valid(valid_a), .out_ready(ready_a),
        .byte_count(cnt_a), .overflow(ovf_a), .timeout(to_a)
    );

    rx_block_assembler #(.BYTES(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .d_in(d_in), .rx_done(rx_b),
        .d_out(d_out_b), .out_valid(valid_b), .out_ready(ready_b),
        .byte_count(cnt_b), .overflow(ovf_b), .timeout(to_b)
    );

    rx_block_assembler #(.TIMEOUT(100)) dut_c (
        .clk(clk), .reset(reset), .d_in(d_in), .rx_done(rx_c),
        .d_out(d_out_c), .out_valid(valid_c), .out_ready(ready_c),
        .byte_count(cnt_c), .overflow(ovf_c), .timeout(to_c)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send(input int sel, input logic [7:0] b);
        d_in = b;
        rx_a = (sel == 0);
        rx_b = (sel == 1);
        rx_c = (sel == 2);
        @(negedge clk);
        rx_a = 1'b0;
        rx_b = 1'b0;
        rx_c = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0;
        d_in = 8'h00;
        rx_a = 1'b0; rx_b = 1'b0; rx_c = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        tick(); tick();
        check("rst_dout", d_out_a, 128'h0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_count", cnt_a, 5'd0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_to", to_a, 1'b0);
        reset = 1'b1;
        tick();

        // Default configuration, consumer always ready.
        ready_a = 1'b1;
        for (int i = 0; i < 15; i++) send(0, 8'(i));
        check("t1_valid_early", valid_a, 1'b0);
        check("t1_count15", cnt_a, 5'd15);
        send(0, 8'h0F);
        check("t1_valid", valid_a, 1'b1);
        check("t1_dout", d_out_a, 128'h000102030405060708090A0B0C0D0E0F);
        check("t1_count0", cnt_a, 5'd0);
        tick();
        check("t1_valid_clear", valid_a, 1'b0);

        // Backpressure: two blocks, then an overflowing byte.
        ready_a = 1'b0;
        for (int i = 0; i < 16; i++) send(0, 8'(8'h10 + i));
        check("t2_valid1", valid_a, 1'b1);
        check("t2_dout1", d_out_a, 128'h101112131415161718191A1B1C1D1E1F);
        for (int i = 0; i < 16; i++) send(0, 8'(8'h20 + i));
        check("t2_hold", d_out_a, 128'h101112131415161718191A1B1C1D1E1F);
        check("t2_full_count", cnt_a, 5'd16);
        check("t2_ovf_before", ovf_a, 1'b0);
        send(0, 8'hFF);
        check("t2_ovf", ovf_a, 1'b1);
        check("t2_hold2", d_out_a, 128'h101112131415161718191A1B1C1D1E1F);
        tick();
        check("t2_ovf_pulse", ovf_a, 1'b0);
        ready_a = 1'b1;
        tick();
        check("t2_valid2", valid_a, 1'b1);
        check("t2_dout2", d_out_a, 128'h202122232425262728292A2B2C2D2E2F);
        check("t2_count_after", cnt_a, 5'd0);
        tick();
        check("t2_valid_clear", valid_a, 1'b0);

        // Final byte on the same edge the held block is accepted.
        ready_a = 1'b0;
        for (int i = 0; i < 16; i++) send(0, 8'(8'h30 + i));
        for (int i = 0; i < 15; i++) send(0, 8'(8'h40 + i));
        check("t3_held", d_out_a, 128'h303132333435363738393A3B3C3D3E3F);
        ready_a = 1'b1;
        send(0, 8'h4F);
        ready_a = 1'b0;
        check("t3_valid", valid_a, 1'b1);
        check("t3_dout", d_out_a, 128'h404142434445464748494A4B4C4D4E4F);
        check("t3_no_ovf", ovf_a, 1'b0);
        check("t3_count", cnt_a, 5'd0);

        // Reset mid-block while a block is still held.
        for (int i = 0; i < 7; i++) send(0, 8'(8'h50 + i));
        check("t4_count7", cnt_a, 5'd7);
        reset = 1'b0;
        tick();
        check("t4_dout", d_out_a, 128'h0);
        check("t4_valid", valid_a, 1'b0);
        check("t4_count", cnt_a, 5'd0);
        check("t4_ovf", ovf_a, 1'b0);
        check("t4_to", to_a, 1'b0);
        reset = 1'b1;
        ready_a = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(0, 8'(8'h60 + i));
        check("t4_valid_new", valid_a, 1'b1);
        check("t4_dout_new", d_out_a, 128'h606162636465666768696A6B6C6D6E6F);

        // LSB-first, 4-byte blocks.
        ready_b = 1'b1;
        send(1, 8'hA1);
        send(1, 8'hB2);
        check("t5_count2", cnt_b, 3'd2);
        send(1, 8'hC3);
        check("t5_valid_early", valid_b, 1'b0);
        send(1, 8'hD4);
        check("t5_valid", valid_b, 1'b1);
        check("t5_dout", d_out_b, 32'hD4C3B2A1);
        check("t5_flags", {ovf_b, to_b}, 2'b00);

        // Inter-byte timeout of 100 cycles.
        ready_c = 1'b1;
        for (int i = 0; i < 5; i++) send(2, 8'(8'hE0 + i));
        check("t6_count5", cnt_c, 5'd5);
        n = 0;
        while (!to_c && n < 200) begin
            tick();
            n++;
        end
        check("t6_latency", n, 100);
        check("t6_count0", cnt_c, 5'd0);
        tick();
        check("t6_pulse", to_c, 1'b0);
        for (int i = 0; i < 16; i++) send(2, 8'(8'h70 + i));
        check("t6_valid", valid_c, 1'b1);
        check("t6_dout", d_out_c, 128'h707172737475767778797A7B7C7D7E7F);
        check("t6_no_ovf", ovf_c, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_block_assembler.md
RX_BLOCK_ASSEMBLER -- requirements
Module: rx_block_assembler

Interface
REQ-001 SHALL have parameter BYTES, default 16, giving the number of bytes per output block (legal range 2..64).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = first received byte lands in the most significant byte of the block; 0 = first received byte lands in the least significant byte.
REQ-003 SHALL have parameter TIMEOUT, default 0, giving the inter-byte idle limit in clk cycles; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port d_in, input, 8 bits: byte from the UART receiver.
REQ-007 SHALL have port rx_done, input, 1 bit: one-cycle strobe marking d_in valid.
REQ-008 SHALL have port d_out, output, 8*BYTES bits: the assembled block.
REQ-009 SHALL have port out_valid, output, 1 bit: d_out holds a complete block.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the block.
REQ-011 SHALL have port byte_count, output, clog2(BYTES)+1 bits: number of bytes in the partial block.
REQ-012 SHALL have port overflow, output, 1 bit: one-cycle pulse when a byte is dropped.
REQ-013 SHALL have port timeout, output, 1 bit: one-cycle pulse when a partial block is discarded.

Function
REQ-014 SHALL hold an assembly register and a separate output register (double buffer).
REQ-015 SHALL run the assembly FSM in one of three states: IDLE (byte_count=0), FILL (0<byte_count<BYTES), FULL (assembly register complete but not yet transferred).
REQ-016 SHALL, in IDLE or FILL on rx_done=1, store d_in at byte slot byte_count and increment byte_count. MSB_FIRST=1 uses slot bits [8*(BYTES-k)-1 -: 8] for byte k; MSB_FIRST=0 uses bits [8k+7 -: 8].
REQ-017 SHALL consider the output register free in a cycle when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-018 SHALL, when the byte completing the block is accepted and the output register is free in that cycle, load d_out, set out_valid=1 on the next edge (latency 1 cycle from the final rx_done), and return to IDLE.
REQ-019 SHALL otherwise enter FULL, and SHALL transfer the block to d_out, with out_valid=1, on the first edge at which the output register is free, returning to IDLE.
REQ-020 SHALL keep d_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL clear out_valid on an out_ready=1 edge unless a new block is transferred on that same edge, in which case out_valid stays 1 with the new d_out.
REQ-022 SHALL, on rx_done=1 in FULL, drop d_in and pulse overflow for 1 cycle; the stored block is unchanged.
REQ-023 SHALL, when TIMEOUT>0 in FILL, count cycles since the last accepted byte. When the count reaches TIMEOUT without rx_done, it discards the partial block, sets byte_count=0 in IDLE and pulses timeout for 1 cycle.
REQ-024 SHALL never apply the timeout in IDLE or FULL.
REQ-025 SHALL give rx_done priority over timeout when both occur in the same cycle.
REQ-026 SHALL clear to zero any unwritten slots of the assembly register at the start of each block.

Reset
REQ-027 SHALL, on reset=0 at a clk edge, set d_out=0, out_valid=0, byte_count=0, overflow=0, timeout=0, the FSM to IDLE, and clear the assembly register and the idle counter.
REQ-028 SHALL, on reset mid-block or while out_valid=1, discard all data with no further pulses.

Verification
REQ-029 SHALL cover: defaults, out_ready=1, bytes 0x00..0x0F sent -> d_out=0x000102030405060708090A0B0C0D0E0F, out_valid=1 exactly 1 cycle after the 16th rx_done.
REQ-030 SHALL cover: MSB_FIRST=0, BYTES=4, bytes 0xA1,0xB2,0xC3,0xD4 sent -> d_out=0xD4C3B2A1.
REQ-031 SHALL cover: out_ready=0, 32 bytes then a 33rd byte sent -> first block held on d_out, second block in FULL, overflow pulses once on the 33rd byte; raising out_ready -> second block on d_out 1 cycle later, out_valid held at 1.
REQ-032 SHALL cover: TIMEOUT=100, 5 bytes then idle -> timeout pulses 100 cycles after the 5th byte, byte_count=0; next 16 bytes form a correct block.
REQ-033 SHALL cover: reset=0 after 7 bytes -> all outputs 0; next 16 bytes produce a clean block.
REQ-034 SHALL cover: final byte arriving on the same edge as out_ready=1 on a held block -> new block loaded, out_valid stays 1, no overflow.
